universal_ff_bank: RTL and testbench

UNIVERSAL_FF_BANK -- requirements
Module: universal_ff_bank

---
 rtl/ff_pkg.sv | 15 +
 rtl/universal_ff_bank_tick_gen.sv | 24 ++
 rtl/universal_ff_bank.sv | 42 ++++
 tb/tb_universal_ff_bank.sv | 112 +++++++++++
 4 files changed

// File: rtl/ff_pkg.sv
// ff_pkg: mode encodings and per-channel next-state function for universal_ff_bank
package ff_pkg;
   localparam logic [1:0] MODE_JK = 2'b00;
   localparam logic [1:0] MODE_D  = 2'b01;
   localparam logic [1:0] MODE_T  = 2'b10;
   localparam logic [1:0] MODE_SR = 2'b11;
   // Bitwise over all channels; SR with S=R=1 holds (the error is flagged elsewhere)
   function automatic logic [31:0] ff_next(input logic [1:0] mode, input logic [31:0] q,
                                           input logic [31:0] j, input logic [31:0] k);
      return mode == MODE_JK ? (j & ~q) | (~k & q)
           : mode == MODE_D  ? j
           : mode == MODE_T  ? q ^ j
           : (j & ~k) | (q & (j | ~k));
   endfunction
endpackage

// File: rtl/universal_ff_bank_tick_gen.sv
// tick_gen: prescaler counting 0..DIV-1, Tick high while the count sits at DIV-1
module tick_gen #(
   parameter int DIV = 25_000_000
) (
   input  logic Clk,
   input  logic nReset,
   output logic Tick
);
   localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          tick_q;
   assign cnt_d = cnt_q == LAST ? '0 : cnt_q + CW'(1);
   // Tick is registered from the next count so the cycle after reset always shows Tick=0
   always_ff @(posedge Clk)
      if (!nReset) begin
         cnt_q  <= '0;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= cnt_d == LAST;
      end
   assign Tick = tick_q;
endmodule

// File: rtl/universal_ff_bank.sv
// universal_ff_bank: WIDTH JK/D/T/SR flip-flops updated on a prescaled tick, with parallel load
module universal_ff_bank
   import ff_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIV   = 25_000_000
) (
   input  logic             Clk,
   input  logic             nReset,
   input  logic [WIDTH-1:0] J,
   input  logic [WIDTH-1:0] K,
   input  logic [1:0]       Mode,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ErrClr,
   output logic [WIDTH-1:0] Q,
   output logic [WIDTH-1:0] Qbar,
   output logic             Tick,
   output logic [WIDTH-1:0] Err
);
   logic [WIDTH-1:0] q_q, q_d, err_q, err_d, sr_bad;
   logic             tick;
   tick_gen #(.DIV(DIV)) u_tick (.Clk(Clk), .nReset(nReset), .Tick(tick));
   assign sr_bad = tick && !Load && Mode == MODE_SR ? J & K : '0;
   assign q_d    = Load ? LoadVal
                 : tick ? WIDTH'(ff_next(Mode, 32'(q_q), 32'(J), 32'(K)))
                 : q_q;
   // A new S=R=1 event outranks a simultaneous clear
   assign err_d  = (ErrClr ? '0 : err_q) | sr_bad;
   always_ff @(posedge Clk)
      if (!nReset) begin
         q_q   <= '0;
         err_q <= '0;
      end else begin
         q_q   <= q_d;
         err_q <= err_d;
      end
   assign Q    = q_q;
   assign Qbar = ~q_q;
   assign Tick = tick;
   assign Err  = err_q;
endmodule

// File: tb/tb_universal_ff_bank.sv
// tb_universal_ff_bank: per-cycle vector table on a WIDTH=4/DIV=4 bank plus a DIV=1 toggle sequence
module tb_universal_ff_bank;
   import ff_pkg::*;
   typedef struct {
      logic       rst_n;
      logic [1:0] mode;
      logic [3:0] j, k;
      logic       load;
      logic [3:0] lv;
      logic       clr;
      logic [3:0] eq;
      logic       et;
      logic [3:0] ee;
   } vec_t;
   vec_t vecs[$];
   logic       Clk = 1'b0;
   logic       nReset, Load, ErrClr, Tick;
   logic [3:0] J, K, LoadVal, Q, Qbar, Err;
   logic [1:0] Mode;
   logic       r1, load1, clr1, tick1;
   logic [3:0] j1, k1, lv1, q1, qbar1, err1;
   logic [1:0] mode1;
   int         vectors = 0;
   int         miscompares = 0;
   always #5 Clk = ~Clk;
   universal_ff_bank #(.WIDTH(4), .DIV(4)) u0 (
      .Clk(Clk), .nReset(nReset), .J(J), .K(K), .Mode(Mode), .Load(Load), .LoadVal(LoadVal),
      .ErrClr(ErrClr), .Q(Q), .Qbar(Qbar), .Tick(Tick), .Err(Err));
   universal_ff_bank #(.WIDTH(4), .DIV(1)) u1 (
      .Clk(Clk), .nReset(r1), .J(j1), .K(k1), .Mode(mode1), .Load(load1), .LoadVal(lv1),
      .ErrClr(clr1), .Q(q1), .Qbar(qbar1), .Tick(tick1), .Err(err1));
   task automatic add(input int n, input logic r, input logic [1:0] m, input logic [3:0] j,
                      input logic [3:0] k, input logic ld, input logic [3:0] lv, input logic c,
                      input logic [3:0] q, input logic t, input logic [3:0] e);
      repeat (n) vecs.push_back('{r, m, j, k, ld, lv, c, q, t, e});
   endtask
   task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", name, got, want);
      end
   endtask
   initial begin
      {nReset, Load, ErrClr, J, K, LoadVal, Mode} = '0;
      {r1, load1, clr1, lv1} = '0;
      j1 = 4'h1; k1 = 4'h1; mode1 = MODE_JK;
      add(1, 0, MODE_JK, 4'h0, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(3, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(1, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 1, 4'h0);
      add(3, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'hF, 0, 4'h0);
      add(1, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'hF, 1, 4'h0);
      add(3, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(1, 1, MODE_JK, 4'hF, 4'hF, 0, 4'h0, 0, 4'h0, 1, 4'h0);
      add(3, 1, MODE_D,  4'hA, 4'h0, 0, 4'h0, 0, 4'hF, 0, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 1, 4'h5, 0, 4'hF, 1, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 0, 4'h0, 0, 4'h5, 0, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 1, 4'h3, 0, 4'h5, 0, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 0, 4'h0, 0, 4'h3, 0, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 0, 4'h0, 0, 4'h3, 1, 4'h0);
      add(1, 1, MODE_D,  4'hA, 4'h0, 1, 4'h0, 0, 4'hA, 0, 4'h0);
      add(2, 1, MODE_SR, 4'hC, 4'hA, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(1, 1, MODE_SR, 4'hC, 4'hA, 0, 4'h0, 0, 4'h0, 1, 4'h0);
      add(1, 1, MODE_SR, 4'h0, 4'h0, 0, 4'h0, 1, 4'h4, 0, 4'h8);
      add(2, 1, MODE_SR, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 0, 4'h0);
      add(1, 1, MODE_SR, 4'h8, 4'h8, 0, 4'h0, 1, 4'h4, 1, 4'h0);
      add(3, 1, MODE_SR, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 0, 4'h8);
      add(1, 1, MODE_SR, 4'h0, 4'h0, 0, 4'h0, 0, 4'h4, 1, 4'h8);
      add(1, 1, MODE_SR, 4'h0, 4'h0, 1, 4'h0, 0, 4'h4, 0, 4'h8);
      add(2, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h8);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'h8);
      add(3, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h5, 0, 4'h8);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h5, 1, 4'h8);
      add(3, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h8);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'h8);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h5, 0, 4'h8);
      add(1, 0, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h5, 0, 4'h8);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(2, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 0, 4'h0);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h0, 1, 4'h0);
      add(1, 1, MODE_T,  4'h5, 4'h0, 0, 4'h0, 0, 4'h5, 0, 4'h0);
      repeat (2) @(posedge Clk);
      foreach (vecs[i]) begin
         @(negedge Clk);
         check($sformatf("v%0d q", i), Q, vecs[i].eq);
         check($sformatf("v%0d qbar", i), Qbar, ~vecs[i].eq);
         check($sformatf("v%0d tick", i), {3'b0, Tick}, {3'b0, vecs[i].et});
         check($sformatf("v%0d err", i), Err, vecs[i].ee);
         nReset  = vecs[i].rst_n;
         Mode    = vecs[i].mode;
         J       = vecs[i].j;
         K       = vecs[i].k;
         Load    = vecs[i].load;
         LoadVal = vecs[i].lv;
         ErrClr  = vecs[i].clr;
      end
      @(negedge Clk);
      check("div1 reset q", q1, 4'h0);
      check("div1 reset qbar", qbar1, 4'hF);
      check("div1 reset tick", {3'b0, tick1}, 4'h0);
      r1 = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge Clk);
         check($sformatf("div1 c%0d tick", i), {3'b0, tick1}, 4'h1);
         check($sformatf("div1 c%0d q", i), q1, 4'(i & 1));
         check($sformatf("div1 c%0d qbar", i), qbar1, ~4'(i & 1));
         check($sformatf("div1 c%0d err", i), err1, 4'h0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
